// File: rtl/nebula_pkg.sv
// rtl/nebula_pkg.sv - Nebula cluster shared types for L1-to-L2 request/response traffic
package nebula_pkg;

    localparam int NUM_CORES = 4;
    localparam int CORE_ID_W = $clog2(NUM_CORES);

    typedef logic [CORE_ID_W-1:0] core_id_t;

    typedef enum logic [1:0] {
        L2_OP_REFILL    = 2'd0,
        L2_OP_WRITEBACK = 2'd1,
        L2_OP_AMO       = 2'd2
    } l2_op_e;

    typedef struct packed {
        logic        valid;
        core_id_t    core_id;
        l2_op_e      op;
        logic        is_ifetch;
        logic [31:0] addr;
        logic [63:0] wdata;
    } l2_req_t;

    typedef struct packed {
        logic        valid;
        core_id_t    core_id;
        logic [63:0] rdata;
    } l2_resp_t;

endpackage

// File: rtl/nebula_rr_arbiter.sv
// rtl/nebula_rr_arbiter.sv - combinational round-robin pick starting at a pointer, with wrap-around
module nebula_rr_arbiter #(
    parameter int N = 4,
    parameter int W = 2
) (
    input  logic [N-1:0] req_i,
    input  logic [W-1:0] ptr_i,
    output logic [N-1:0] gnt_o,
    output logic [W-1:0] idx_o,
    output logic         any_o
);

    // First requester found walking upward from ptr_i wins.
    always_comb begin
        int j;
        j     = 0;
        gnt_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        for (int off = 0; off < N; off++) begin
            j = (int'(ptr_i) + off) % N;
            if (!any_o && req_i[j]) begin
                any_o    = 1'b1;
                gnt_o[j] = 1'b1;
                idx_o    = W'(j);
            end
        end
    end

endmodule

// File: rtl/nebula_l2_req_arb.sv
// rtl/nebula_l2_req_arb.sv - round-robin arbiter from per-core L1 request ports onto the shared L2 request channel
// Build option: NEBULA_L2ARB_IFETCH_PRIO_EN gives eligible ifetch requests strict priority over the rest.
module nebula_l2_req_arb
    import nebula_pkg::*;
#(
    parameter int NUM_REQ = NUM_CORES
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  l2_req_t            req_i [NUM_REQ],
    output logic [NUM_REQ-1:0] req_ready_o,
    output l2_req_t            l2_req_o,
    input  logic               l2_req_ready_i,
    input  l2_resp_t           l2_resp_i,
    output l2_resp_t           resp_o [NUM_REQ],
    output logic [NUM_REQ-1:0] pending_o,
    output logic               resp_err_o
);

    localparam int L2_ARB_PTR_W = $clog2(NUM_REQ);

    l2_req_t                   l2_req_q,   l2_req_d;
    logic [NUM_REQ-1:0]        pending_q,  pending_d;
    logic [L2_ARB_PTR_W-1:0]   rr_ptr_q,   rr_ptr_d;
    logic                      resp_err_q, resp_err_d;

    logic [NUM_REQ-1:0]        eligible;
    logic [NUM_REQ-1:0]        win_gnt;
    logic [L2_ARB_PTR_W-1:0]   win_idx;
    logic                      win_any;
    logic                      out_free;

    // A requester with an outstanding request sits out until its response returns.
    always_comb begin
        eligible = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            eligible[i] = req_i[i].valid && !pending_q[i];
        end
    end

`ifdef NEBULA_L2ARB_IFETCH_PRIO_EN
    logic [NUM_REQ-1:0]      elig_if,  elig_nf;
    logic [NUM_REQ-1:0]      gnt_if,   gnt_nf;
    logic [L2_ARB_PTR_W-1:0] idx_if,   idx_nf;
    logic                    any_if,   any_nf;

    // Split eligible requesters into ifetch and data classes.
    always_comb begin
        elig_if = '0;
        elig_nf = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            elig_if[i] = eligible[i] &&  req_i[i].is_ifetch;
            elig_nf[i] = eligible[i] && !req_i[i].is_ifetch;
        end
    end

    nebula_rr_arbiter #(.N(NUM_REQ), .W(L2_ARB_PTR_W)) u_arb_ifetch (
        .req_i (elig_if),
        .ptr_i (rr_ptr_q),
        .gnt_o (gnt_if),
        .idx_o (idx_if),
        .any_o (any_if)
    );

    nebula_rr_arbiter #(.N(NUM_REQ), .W(L2_ARB_PTR_W)) u_arb_data (
        .req_i (elig_nf),
        .ptr_i (rr_ptr_q),
        .gnt_o (gnt_nf),
        .idx_o (idx_nf),
        .any_o (any_nf)
    );

    assign win_gnt = any_if ? gnt_if : gnt_nf;
    assign win_idx = any_if ? idx_if : idx_nf;
    assign win_any = any_if || any_nf;
`else
    nebula_rr_arbiter #(.N(NUM_REQ), .W(L2_ARB_PTR_W)) u_arb (
        .req_i (eligible),
        .ptr_i (rr_ptr_q),
        .gnt_o (win_gnt),
        .idx_o (win_idx),
        .any_o (win_any)
    );
`endif

    assign out_free    = !l2_req_q.valid || l2_req_ready_i;
    assign req_ready_o = (out_free && !rst_i) ? win_gnt : '0;

    // Response fan-out: every port sees the payload, only the addressed core sees valid.
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            resp_o[i]       = l2_resp_i;
            resp_o[i].valid = l2_resp_i.valid && (int'(l2_resp_i.core_id) == i);
        end
    end

    // Next state: load the output stage on a grant, retire pending bits on responses.
    always_comb begin
        logic resp_hit;
        l2_req_d   = l2_req_q;
        pending_d  = pending_q;
        rr_ptr_d   = rr_ptr_q;
        resp_err_d = resp_err_q;
        resp_hit   = 1'b0;

        if (l2_resp_i.valid) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (int'(l2_resp_i.core_id) == i) begin
                    resp_hit     = 1'b1;
                    if (!pending_q[i]) begin
                        resp_err_d = 1'b1;
                    end
                    pending_d[i] = 1'b0;
                end
            end
            // A core_id beyond the populated ports can never have a pending request.
            if (!resp_hit) begin
                resp_err_d = 1'b1;
            end
        end

        if (out_free) begin
            if (win_any) begin
                l2_req_d           = req_i[win_idx];
                l2_req_d.core_id   = core_id_t'(win_idx);
                l2_req_d.valid     = 1'b1;
                pending_d[win_idx] = 1'b1;
                rr_ptr_d           = L2_ARB_PTR_W'((int'(win_idx) + 1) % NUM_REQ);
            end else begin
                l2_req_d.valid = 1'b0;
            end
        end
    end

    // State registers; reset discards any held request and all outstanding tracking.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            l2_req_q   <= '0;
            pending_q  <= '0;
            rr_ptr_q   <= '0;
            resp_err_q <= 1'b0;
        end else begin
            l2_req_q   <= l2_req_d;
            pending_q  <= pending_d;
            rr_ptr_q   <= rr_ptr_d;
            resp_err_q <= resp_err_d;
        end
    end

    assign l2_req_o   = l2_req_q;
    assign pending_o  = pending_q;
    assign resp_err_o = resp_err_q;

endmodule
